conv_line_ctrl: RTL and testbench
=================================

Name: conv_line_ctrl

Overview:
Sequencer for one 5-tap convolution line (chained processing elements plus output saturation). Runs one row per job in three steps: loads the tap weights, streams the row's pixels into the line, then drains the pipeline. Generates the datapath clock-enable, weight-select and output-valid strobes. Sits between the row buffer / weight memory and the convolution line datapath.

Parameters:
I_X, 8, pixel width
I_W, 8, weight width
TAPS, 5, number of PEs in the line
PIPE_LAT, 5, datapath register stages from o_x to saturated output
LEN_W, 8, width of row-length field

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  job start pulse, sampled only in IDLE
i_cfg_len  in  LEN_W  row length in pixels, latched on accepted i_start
i_w_valid  in  1  weight word valid
o_w_ready  out  1  weight word accepted when high with i_w_valid
i_w_data  in  I_W  weight word
i_x_valid  in  1  pixel valid
o_x_ready  out  1  pixel accepted when high with i_x_valid
i_x_data  in  I_X  pixel
o_w_sel  out  TAPS  one-hot PE weight-register write select
o_w  out  I_W  weight to datapath
o_x  out  I_X  pixel to datapath
o_x_en  out  1  datapath advance enable (PE register clock-enable)
o_out_valid  out  1  saturated datapath output is a valid convolution result this cycle
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse at job end
o_err  out  1  one-cycle pulse on rejected job
o_stall_cnt  out  16  starved-cycle count (see Optional Feature)

Behaviour:
- Reset (asynchronous, i_rst_n low): FSM to IDLE. All outputs 0. Counters and valid shift register cleared. Reset mid-job aborts the job; no o_done.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - i_start with i_cfg_len >= TAPS: latch length, go to LOAD_W.
  - i_start with i_cfg_len < TAPS: pulse o_err next cycle, stay in IDLE.
  - i_start in any other state is ignored.
- LOAD_W:
  - o_w_ready=1.
  - Each accepted word k (0..TAPS-1) drives o_w=i_w_data and o_w_sel=1<<k in the same cycle (combinational pass-through). Datapath writes on that edge.
  - After word TAPS-1, go to STREAM. o_x_en=0 throughout.
- STREAM:
  - o_x_ready=1. o_x_en = i_x_valid (pipeline advances only on an accepted pixel). o_x = i_x_data.
  - Pixel index p counts 0..len-1 on accepts.
  - The valid-input bit into the valid shift register is (p >= TAPS-1).
  - After accepting pixel len-1, go to DRAIN.
  - i_x_valid low: no advance, no counter change.
- DRAIN:
  - o_x_en=1 and o_x=0 for exactly PIPE_LAT cycles; the shift register is fed 0.
  - Then go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- Valid tracking:
  - PIPE_LAT-deep shift register, advancing only when o_x_en=1.
  - o_out_valid = tail bit AND o_x_en.
  - Exactly len-TAPS+1 o_out_valid pulses per job, all before o_done.
- Boundaries:
  - len == TAPS gives exactly one output.
  - len = 2^LEN_W-1 gives no counter wrap; the counter is LEN_W bits and compares for equality.
  - Weight and pixel handshakes are never active in the same cycle.

Optional Feature:
CONV_CTRL_STALL_CNT_EN
- Defined: o_stall_cnt counts cycles in STREAM with i_x_valid=0.
  - Cleared on accepted i_start.
  - Saturates at 16'hFFFF.
  - Holds its value after job end.
- Undefined: o_stall_cnt tied to 0 and no counter logic is generated.

Decomposition:
- Shared package (conv_pkg):
  - FSM state enum.
  - Default TAPS, PIPE_LAT, I_X, I_W constants.
  - Stall-counter width constant (16).
- One sub-module, conv_valid_pipe: PIPE_LAT-deep enable-gated shift register producing o_out_valid.

Test Plan:
- Weights 1..5, then len=8 with pixels 1..8 streamed back-to-back.
  - Expect 5 o_w_sel one-hot writes 00001..10000.
  - Expect 4 o_out_valid pulses: first on the cycle of the PIPE_LAT-th o_x_en after pixel 5 is accepted, last in DRAIN.
  - o_done on the cycle after the last DRAIN cycle; o_busy high from the cycle after i_start to the DONE cycle.
- len=5 -> exactly 1 o_out_valid. len=3 -> o_err pulse, o_busy stays 0, no o_w_ready.
- Same job as the first test, with i_x_valid low for 3 cycles after pixel 4.
  - Expect o_x_en=0 on those cycles and o_out_valid timing shifted by 3.
  - With CONV_CTRL_STALL_CNT_EN: o_stall_cnt=3.
- i_start asserted during STREAM -> ignored; the job completes with the original len.
- i_rst_n low in the middle of DRAIN -> all outputs 0 immediately, no o_done. A new job of len=6 afterwards yields 2 valids.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared types and default constants for the 5-tap convolution
//            line controller (FSM state encoding, default geometry, stall
//            counter width).
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Controller phases: idle, weight load, pixel stream, pipeline drain,
    // one-cycle completion.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } conv_state_t;

    localparam int c_TAPS        = 5;
    localparam int c_PIPE_LAT    = 5;
    localparam int c_I_X         = 8;
    localparam int c_I_W         = 8;
    localparam int c_LEN_W       = 8;
    localparam int c_STALL_CNT_W = 16;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : conv_valid_pipe
// Purpose  : Enable-gated shift register that follows a "this pixel completes
//            a full window" tag through the datapath latency. It moves only
//            when the datapath advances, so it stays aligned with the PEs.
// Ports    : i_clk, i_rst_n  - clock, async active-low reset
//            i_en            - datapath advance enable
//            i_valid         - tag entering with the current pixel
//            o_valid         - tail tag qualified by i_en
// Revision : 1.0 - initial release
// ============================================================================
module conv_valid_pipe
    import conv_pkg::*;
#(
    parameter int PIPE_LAT = c_PIPE_LAT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_valid,
    output logic o_valid
);

    logic [PIPE_LAT-1:0] r_sr;

    generate
        if (PIPE_LAT == 1) begin : g_single
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)  r_sr <= '0;
                else if (i_en) r_sr <= i_valid;
            end
        end else begin : g_multi
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)  r_sr <= '0;
                else if (i_en) r_sr <= {r_sr[PIPE_LAT-2:0], i_valid};
            end
        end
    endgenerate

    // The saturated output only changes on an advancing cycle, so the tail
    // tag is a result strobe only while the pipeline is moving.
    assign o_valid = r_sr[PIPE_LAT-1] & i_en;

endmodule : conv_valid_pipe
`default_nettype wire

// File: rtl/conv_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_line_ctrl
// Purpose  : Sequencer for one 5-tap convolution line. Per job: loads TAPS
//            weights, streams cfg_len pixels, drains PIPE_LAT stages, then
//            pulses o_done. Generates the datapath enable, weight select and
//            output-valid strobes.
// Ports    : i_start/i_cfg_len      - job request (sampled only in IDLE)
//            i_w_*/o_w_ready         - weight word handshake
//            i_x_*/o_x_ready         - pixel handshake
//            o_w_sel/o_w/o_x/o_x_en  - datapath controls
//            o_out_valid             - result strobe
//            o_busy/o_done/o_err     - status
//            o_stall_cnt             - starved STREAM cycles
// Options  : CONV_CTRL_STALL_CNT_EN enables the stall counter; otherwise
//            o_stall_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module conv_line_ctrl
    import conv_pkg::*;
#(
    parameter int I_X      = c_I_X,
    parameter int I_W      = c_I_W,
    parameter int TAPS     = c_TAPS,
    parameter int PIPE_LAT = c_PIPE_LAT,
    parameter int LEN_W    = c_LEN_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [LEN_W-1:0]         i_cfg_len,
    input  logic                     i_w_valid,
    output logic                     o_w_ready,
    input  logic [I_W-1:0]           i_w_data,
    input  logic                     i_x_valid,
    output logic                     o_x_ready,
    input  logic [I_X-1:0]           i_x_data,
    output logic [TAPS-1:0]          o_w_sel,
    output logic [I_W-1:0]           o_w,
    output logic [I_X-1:0]           o_x,
    output logic                     o_x_en,
    output logic                     o_out_valid,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [c_STALL_CNT_W-1:0] o_stall_cnt
);

    localparam logic [LEN_W-1:0] c_TAPS_L   = LEN_W'(TAPS);
    localparam logic [LEN_W-1:0] c_TAPS_M1  = LEN_W'(TAPS - 1);
    localparam logic [LEN_W-1:0] c_DRAIN_M1 = LEN_W'(PIPE_LAT - 1);

    conv_state_t      r_state, w_state_nxt;
    logic [LEN_W-1:0] r_len;
    // One counter serves all phases: weight index, pixel index, drain cycle.
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_err;
    logic             w_start_ok;
    logic             w_start_bad;
    logic             w_vin;

    assign w_start_ok  = (r_state == ST_IDLE) && i_start && (i_cfg_len >= c_TAPS_L);
    assign w_start_bad = (r_state == ST_IDLE) && i_start && (i_cfg_len <  c_TAPS_L);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_start_bad;
            if (w_start_ok) r_len <= i_cfg_len;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_w_ready   = 1'b0;
        o_x_ready   = 1'b0;
        o_w_sel     = '0;
        o_w         = '0;
        o_x         = '0;
        o_x_en      = 1'b0;
        w_vin       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_LOAD_W;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOAD_W: begin
                o_w_ready = 1'b1;
                if (i_w_valid) begin
                    o_w     = i_w_data;
                    o_w_sel = TAPS'(1) << r_cnt;
                    if (r_cnt == c_TAPS_M1) begin
                        w_state_nxt = ST_STREAM;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + LEN_W'(1);
                    end
                end
            end
            ST_STREAM: begin
                o_x_ready = 1'b1;
                o_x_en    = i_x_valid;
                o_x       = i_x_data;
                if (i_x_valid) begin
                    // Pixel p closes a full window once TAPS pixels are in.
                    w_vin = (r_cnt >= c_TAPS_M1);
                    // Equality against len-1 keeps len = 2^LEN_W-1 wrap-free.
                    if (r_cnt == r_len - LEN_W'(1)) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + LEN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                o_x_en = 1'b1;
                if (r_cnt == c_DRAIN_M1) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + LEN_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_DONE);
    assign o_err  = r_err;

    conv_valid_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_valid_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (o_x_en),
        .i_valid (w_vin),
        .o_valid (o_out_valid)
    );

`ifdef CONV_CTRL_STALL_CNT_EN
    logic [c_STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_start_ok) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_STREAM) && !i_x_valid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + c_STALL_CNT_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

endmodule : conv_line_ctrl
`default_nettype wire

// File: tb/tb_conv_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_line_ctrl
// Purpose  : Self-checking bench for conv_line_ctrl. Jobs are driven with
//            random data and optional random gaps; results are compared with
//            a window-count model of when full 5-tap windows reach the output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_line_ctrl;

    localparam int TAPS     = 5;
    localparam int PIPE_LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic        w_valid = 1'b0;
    logic [7:0]  w_data = '0;
    logic        x_valid = 1'b0;
    logic [7:0]  x_data = '0;
    logic        w_ready, x_ready, x_en, out_valid, busy, done, err;
    logic [4:0]  w_sel;
    logic [7:0]  w_out, x_out;
    logic [15:0] stall_cnt;

    conv_line_ctrl u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_cfg_len   (cfg_len),
        .i_w_valid   (w_valid),
        .o_w_ready   (w_ready),
        .i_w_data    (w_data),
        .i_x_valid   (x_valid),
        .o_x_ready   (x_ready),
        .i_x_data    (x_data),
        .o_w_sel     (w_sel),
        .o_w         (w_out),
        .o_x         (x_out),
        .o_x_en      (x_en),
        .o_out_valid (out_valid),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations of the most recent job
    int  obs_wr, obs_px, obs_wsel_bad, obs_w_bad, obs_x_bad, obs_xen_bad;
    int  obs_overlap, obs_busy_bad, obs_drain, obs_done_cyc, obs_stall, obs_stray;
    bit  obs_done, obs_timeout, obs_start_busy;
    logic [63:0] obs_abort_outs;
    int  obs_ven[$];
    int  obs_vcyc[$];

    // Model expectations
    int  exp_ven[$];
    int  exp_vcyc[$];
    int  exp_done_cyc;

    function automatic logic [63:0] all_outs();
        return {20'd0, w_ready, x_ready, w_sel, w_out, x_out, x_en, out_valid,
                busy, done, err, stall_cnt};
    endfunction

    // A pixel at stream index p completes a full window when p >= TAPS-1; its
    // result appears on the PIPE_LAT-th advance after it, i.e. at advance
    // number p+PIPE_LAT of the job. Cycle numbers assume gap-free weights and
    // pixels, with hold_n idle cycles inserted after hold_after pixels.
    task automatic model_job(input int len, input int hold_after, input int hold_n);
        exp_ven.delete();
        exp_vcyc.delete();
        for (int p = TAPS - 1; p < len; p++) begin
            int e;
            e = p + PIPE_LAT;
            exp_ven.push_back(e);
            exp_vcyc.push_back(TAPS + e + ((hold_after >= 0 && e >= hold_after) ? hold_n : 0));
        end
        exp_done_cyc = TAPS + len + PIPE_LAT + ((hold_after >= 0) ? hold_n : 0);
    endtask

    // Drives one job and records what the DUT did; inputs change on negedge,
    // outputs are sampled 1 time unit later.
    task automatic run_job(input int len, input int w_gap, input int x_gap,
                           input int hold_after, input int hold_n,
                           input bit inject_start, input bit abort_drain);
        int  k, en_idx, hold_left;
        bit  injected;
        obs_wr = 0; obs_px = 0; obs_wsel_bad = 0; obs_w_bad = 0; obs_x_bad = 0;
        obs_xen_bad = 0; obs_overlap = 0; obs_busy_bad = 0; obs_drain = 0;
        obs_done_cyc = -1; obs_stall = 0; obs_stray = 0; obs_done = 0;
        obs_timeout = 0; obs_abort_outs = '0;
        obs_ven.delete(); obs_vcyc.delete();
        k = 0; en_idx = 0; hold_left = hold_n; injected = 0;
        @(negedge clk);
        start = 1'b1; cfg_len = 8'(len);
        #1 obs_start_busy = busy;
        @(negedge clk);
        start = 1'b0; cfg_len = 8'($urandom);
        for (int c = 0; c < 3000; c++) begin
            w_valid = ($urandom_range(99) >= w_gap);
            w_data  = 8'($urandom);
            x_valid = ($urandom_range(99) >= x_gap);
            x_data  = 8'($urandom);
            if (hold_after >= 0 && x_ready && obs_px == hold_after && hold_left > 0) begin
                x_valid = 1'b0;
                hold_left--;
            end
            if (inject_start && x_ready && !injected) begin
                start = 1'b1; cfg_len = 8'd5; injected = 1;
            end
            #1;
            if (busy !== 1'b1) obs_busy_bad++;
            if (w_ready && x_ready) obs_overlap++;
            if (w_ready && w_valid) begin
                if (w_sel !== (5'(1) << k)) obs_wsel_bad++;
                if (w_out !== w_data) obs_w_bad++;
                k++; obs_wr++;
            end else if (w_sel !== 5'd0) begin
                obs_wsel_bad++;
            end
            if (x_ready) begin
                if (x_en !== x_valid) obs_xen_bad++;
                if (x_valid && x_out !== x_data) obs_x_bad++;
                if (x_valid) obs_px++;
                else         obs_stall++;
            end
            if (x_en && !x_ready) begin
                obs_drain++;
                if (x_out !== 8'd0) obs_x_bad++;
            end
            if (out_valid) begin
                if (!x_en) obs_stray++;
                obs_ven.push_back(en_idx);
                obs_vcyc.push_back(c);
            end
            if (x_en) en_idx++;
            if (done) begin obs_done = 1; obs_done_cyc = c; end
            if (abort_drain && obs_drain == 2) begin
                rst_n = 1'b0;
                #1 obs_abort_outs = all_outs();
                w_valid = 1'b0; x_valid = 1'b0; start = 1'b0;
                return;
            end
            @(negedge clk);
            start = 1'b0;
            if (obs_done) begin
                w_valid = 1'b0; x_valid = 1'b0;
                return;
            end
        end
        obs_timeout = 1;
        w_valid = 1'b0; x_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        w_valid = 1'b1; w_data = 8'hA5; x_valid = 1'b1; x_data = 8'h5A; start = 1'b1; cfg_len = 8'd9;
        #2;
        n_tests++;
        if (all_outs() !== 64'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        repeat (2) @(negedge clk);
        w_valid = 1'b0; x_valid = 1'b0; start = 1'b0;
        rst_n = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_release: busy/done/err %b expected 000", {busy, done, err});
        end
    endtask

    task automatic test_basic();
        int m;
        run_job(8, 0, 0, -1, 0, 0, 0);
        model_job(8, -1, 0);
        n_tests++;
        if (obs_start_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_before: got %0d expected 0", obs_start_busy); end
        n_tests++;
        if (obs_wr !== TAPS || obs_wsel_bad !== 0 || obs_w_bad !== 0) begin
            n_fail++; $display("FAIL basic_weights: writes %0d sel_err %0d data_err %0d expected 5/0/0", obs_wr, obs_wsel_bad, obs_w_bad);
        end
        n_tests++;
        if (obs_ven.size() !== exp_ven.size()) begin
            n_fail++; $display("FAIL basic_valid_count: got %0d expected %0d", obs_ven.size(), exp_ven.size());
        end else begin
            m = 0;
            foreach (exp_vcyc[i]) if (obs_vcyc[i] !== exp_vcyc[i]) m++;
            n_tests++;
            if (m !== 0) begin n_fail++; $display("FAIL basic_valid_timing: %0d cycles differ, first got %0d expected %0d", m, obs_vcyc[0], exp_vcyc[0]); end
        end
        n_tests++;
        if (obs_done !== 1'b1 || obs_done_cyc !== exp_done_cyc) begin
            n_fail++; $display("FAIL basic_done: cycle %0d expected %0d", obs_done_cyc, exp_done_cyc);
        end
        n_tests++;
        if (obs_drain !== PIPE_LAT || obs_busy_bad !== 0 || obs_overlap !== 0 || obs_x_bad !== 0) begin
            n_fail++; $display("FAIL basic_ctrl: drain %0d busy_err %0d overlap %0d x_err %0d expected %0d/0/0/0", obs_drain, obs_busy_bad, obs_overlap, obs_x_bad, PIPE_LAT);
        end
        #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: busy %0d expected 0", busy); end
    endtask

    task automatic test_min_len();
        run_job(5, 0, 0, -1, 0, 0, 0);
        model_job(5, -1, 0);
        n_tests++;
        if (obs_ven.size() !== 1 || obs_vcyc.size() != 1 || obs_vcyc[0] !== exp_vcyc[0]) begin
            n_fail++; $display("FAIL min_len_valid: count %0d expected 1 at cycle %0d", obs_ven.size(), exp_vcyc[0]);
        end
    endtask

    task automatic test_err();
        int bad;
        bad = 0;
        @(negedge clk);
        start = 1'b1; cfg_len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_tests++;
        if ({err, busy, w_ready} !== 3'b100) begin
            n_fail++; $display("FAIL err_pulse: err/busy/w_ready %b expected 100", {err, busy, w_ready});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (err || busy || w_ready) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL err_after: %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_stall();
        int m;
        run_job(8, 0, 0, 4, 3, 0, 0);
        model_job(8, 4, 3);
        n_tests++;
        if (obs_xen_bad !== 0 || obs_stall !== 3) begin
            n_fail++; $display("FAIL stall_xen: xen_err %0d stalls %0d expected 0/3", obs_xen_bad, obs_stall);
        end
        m = (obs_vcyc.size() == exp_vcyc.size()) ? 0 : 99;
        if (m == 0) foreach (exp_vcyc[i]) if (obs_vcyc[i] !== exp_vcyc[i]) m++;
        n_tests++;
        if (m !== 0) begin n_fail++; $display("FAIL stall_valid_timing: %0d differences, count %0d expected %0d", m, obs_vcyc.size(), exp_vcyc.size()); end
        n_tests++;
        if (obs_done_cyc !== exp_done_cyc) begin n_fail++; $display("FAIL stall_done: cycle %0d expected %0d", obs_done_cyc, exp_done_cyc); end
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
`ifdef CONV_CTRL_STALL_CNT_EN
        if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
`else
        if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 0", stall_cnt); end
`endif
    endtask

    task automatic test_start_ignored();
        run_job(8, 0, 0, -1, 0, 1, 0);
        n_tests++;
        if (obs_ven.size() !== 4 || obs_px !== 8 || obs_done !== 1'b1) begin
            n_fail++; $display("FAIL start_ignored: valids %0d pixels %0d done %0d expected 4/8/1", obs_ven.size(), obs_px, obs_done);
        end
    endtask

    task automatic test_reset_drain();
        int bad;
        bad = 0;
        run_job(8, 0, 0, -1, 0, 0, 1);
        n_tests++;
        if (obs_abort_outs !== 64'd0 || obs_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_drain_outs: got %h done %0d expected 0/0", obs_abort_outs, obs_done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (done || busy || out_valid) bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (done || busy) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL reset_drain_quiet: %0d bad cycles expected 0", bad); end
        run_job(6, 0, 0, -1, 0, 0, 0);
        model_job(6, -1, 0);
        n_tests++;
        if (obs_ven.size() !== 2 || obs_done !== 1'b1) begin
            n_fail++; $display("FAIL reset_drain_rerun: valids %0d done %0d expected 2/1", obs_ven.size(), obs_done);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 21; j++) begin
            int len, m;
            len = (j == 20) ? 255 : $urandom_range(40, 5);
            run_job(len, (j == 20) ? 0 : 30, (j == 20) ? 0 : 30, -1, 0, 0, 0);
            model_job(len, -1, 0);
            m = (obs_ven.size() == exp_ven.size()) ? 0 : 1000;
            if (m == 0) foreach (exp_ven[i]) if (obs_ven[i] !== exp_ven[i]) m++;
            m += obs_wsel_bad + obs_w_bad + obs_x_bad + obs_xen_bad + obs_overlap + obs_busy_bad + obs_stray;
            n_tests++;
            if (m !== 0 || obs_timeout || !obs_done || obs_px !== len || obs_wr !== TAPS || obs_drain !== PIPE_LAT) begin
                n_fail++;
                $display("FAIL random_job len=%0d: errs %0d timeout %0d px %0d wr %0d drain %0d valids %0d expected 0/0/%0d/5/%0d/%0d",
                         len, m, obs_timeout, obs_px, obs_wr, obs_drain, obs_ven.size(), len, PIPE_LAT, exp_ven.size());
            end
            #1;
            n_tests++;
`ifdef CONV_CTRL_STALL_CNT_EN
            if (stall_cnt !== 16'(obs_stall)) begin n_fail++; $display("FAIL random_stall_cnt: got %0d expected %0d", stall_cnt, obs_stall); end
`else
            if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL random_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_len();
        test_err();
        test_stall();
        test_start_ignored();
        test_reset_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_conv_line_ctrl
`default_nettype wire
